// File: rtl/dff_chk_pkg.sv
// rtl/dff_chk_pkg.sv - shared types and limits for the DFF stream checker
// Purpose: checker FSM state encoding and the largest supported DUT latency.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - LATENCY-stage {valid, data} shift register with flush
// Purpose: delays each stimulus sample by the DUT latency to form the expected value.
// Ports:
//   clock, rst         - rising-edge clock, asynchronous active-high reset
//   flush              - synchronous clear of every stage (overrides the shift)
//   in_valid, in_data  - sample entering stage 0
//   out_valid, out_data- sample leaving the last stage
module dff_delay_line #(
    parameter int DATA_W  = 1,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [DATA_W-1:0]  dat_q [LATENCY];
    logic [DATA_W-1:0]  dat_d [LATENCY];

    always_comb begin
        vld_d    = '0;
        dat_d[0] = '0;
        if (!flush) begin
            vld_d[0] = in_valid;
            dat_d[0] = in_data;
        end
        for (int i = 1; i < LATENCY; i++) begin
            dat_d[i] = '0;
            if (!flush) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/dff_stream_checker.sv
// rtl/dff_stream_checker.sv - response checker comparing DUT dout to delayed din
// Purpose: runs num_checks comparisons of dout against din delayed LATENCY clocks,
// counting matches/mismatches and recording the index of the first mismatch.
// Ports:
//   clock, rst            - rising-edge clock, asynchronous active-high reset
//   start, num_checks     - begin a run of num_checks comparisons (IDLE/DONE only)
//   din, din_valid        - stimulus sample driven into the DUT this cycle
//   dout                  - DUT output
//   busy, done, pass      - run status; pass valid while done
//   match_count, err_count, first_err - run results (first_err all-ones if none)
module dff_stream_checker
    import dff_chk_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_checks,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_latency_check
        $error("dff_stream_checker: LATENCY must be in 1..%0d", MAX_LATENCY);
    end

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    chk_state_t       state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    // Unsaturated comparison total; supplies the comparison index and end-of-run test.
    logic [CNT_W-1:0] total_q, total_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic              flush;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;

    assign flush = start && (state_q != RUN);

    dff_delay_line #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clock     (clock),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (din_valid && (state_q == RUN)),
        .in_data   (din),
        .out_valid (exp_valid),
        .out_data  (exp_data)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        match_d = match_q;
        err_d   = err_q;
        first_d = first_q;
        total_d = total_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    num_d   = num_checks;
                    match_d = '0;
                    err_d   = '0;
                    first_d = ALL_ONES;
                    total_d = '0;
                end
            end
            RUN: begin
                if (num_q == '0) begin
                    state_d = DONE;
                end else if (exp_valid) begin
                    if (exp_data == dout) begin
                        match_d = match_q + CNT_W'(1);
                    end else begin
                        if (err_q != ALL_ONES) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (first_q == ALL_ONES) begin
                            first_d = total_q;
                        end
                    end
                    total_d = total_q + CNT_W'(1);
                    if (total_d == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            match_q <= '0;
            err_q   <= '0;
            first_q <= ALL_ONES;
            total_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            match_q <= match_d;
            err_q   <= err_d;
            first_q <= first_d;
            total_q <= total_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign match_count = match_q;
    assign err_count   = err_q;
    assign first_err   = first_q;

endmodule

// File: tb/tb_dff_stream_checker.sv
// tb/tb_dff_stream_checker.sv - self-checking bench for dff_stream_checker
module tb_dff_stream_checker;

    localparam int DATA_W  = 4;
    localparam int LATENCY = 1;
    localparam int CNT_W   = 16;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_checks = '0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic [DATA_W-1:0] dout = '0;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  match_count, err_count, first_err;

    bit       fault_now = 1'b0;
    bit       fault_map [64];
    bit [4:0] pat_bits = 5'b01101;   // valid pattern 1,0,1,1,0 (bit 0 first)
    int       n_total = 0;
    int       n_pass = 0;

    typedef struct {
        int n;
        int gap;
        int fault;
        int glitch;
        int e_match;
        int e_err;
        int e_first;
        int e_pass;
    } vec_t;

    vec_t vecs [9];

    dff_stream_checker #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .num_checks  (num_checks),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .match_count (match_count),
        .err_count   (err_count),
        .first_err   (first_err)
    );

    always #5 clock = ~clock;

    // Stand-in DFF under test; fault_now corrupts the captured sample.
    always @(posedge clock) dout <= din ^ {DATA_W{fault_now}};

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 64; i++) fault_map[i] = 1'b0;
    endtask

    // gap: 0 always valid, 1 fixed pattern, 2 random. glitch: cycle to pulse start (-1 none).
    task automatic do_run(input int n, input int gap, input int glitch,
                          output int done_c, output int last_c, output bit busy0);
        int v;
        bit want;
        v = 0;
        done_c = -1;
        last_c = -1;
        busy0 = 1'b0;
        @(posedge clock); #1;
        start = 1'b1;
        num_checks = CNT_W'(n);
        din_valid = 1'b0;
        fault_now = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            case (gap)
                0:       want = 1'b1;
                1:       want = pat_bits[c % 5];
                default: want = ($urandom_range(0, 1) != 0);
            endcase
            din_valid = want;
            din = DATA_W'($urandom);
            fault_now = want && (v < 64) && fault_map[v];
            if (want) begin
                if (v == n - 1) last_c = c;
                v++;
            end
            if (c == glitch) begin
                start = 1'b1;
                num_checks = CNT_W'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (c == 0) busy0 = busy;
            if (done) begin
                done_c = c;
                break;
            end
            @(posedge clock); #1;
        end
        din_valid = 1'b0;
        fault_now = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int done_c, input int last_c,
                                input bit busy0, input int e_match, input int e_err,
                                input int e_first, input int e_pass);
        chk({tag, " done_seen"}, done_c >= 0, 1);
        chk({tag, " done_latency"}, done_c - last_c, 2);
        chk({tag, " busy_in_run"}, busy0, 1);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " match_count"}, match_count, e_match);
        chk({tag, " err_count"}, err_count, e_err);
        chk({tag, " first_err"}, first_err, e_first);
        chk({tag, " pass"}, pass, e_pass);
    endtask

    initial begin
        int  done_c, last_c, n, e_err, e_first;
        bit  busy0;

        //         n   gap fault glitch match err first   pass
        vecs[0] = '{20, 0, -1,   -1,    20,   0,  65535, 1};
        vecs[1] = '{20, 0,  7,   -1,    19,   1,  7,     0};
        vecs[2] = '{10, 1, -1,   -1,    10,   0,  65535, 1};
        vecs[3] = '{0,  0, -1,   -1,    0,    0,  65535, 1};
        vecs[4] = '{10, 0, -1,    3,    10,   0,  65535, 1};
        vecs[5] = '{5,  0,  0,   -1,    4,    1,  0,     0};
        vecs[6] = '{5,  1,  4,   -1,    4,    1,  4,     0};
        vecs[7] = '{5,  0,  5,   -1,    5,    0,  65535, 1};
        vecs[8] = '{1,  0, -1,   -1,    1,    0,  65535, 1};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset match_count", match_count, 0);
        chk("reset err_count", err_count, 0);
        chk("reset first_err", first_err, 16'hFFFF);
        @(posedge clock); #1;
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            clear_faults();
            if (vecs[k].fault >= 0) fault_map[vecs[k].fault] = 1'b1;
            do_run(vecs[k].n, vecs[k].gap, vecs[k].glitch, done_c, last_c, busy0);
            check_result($sformatf("vec%0d", k), done_c, last_c, busy0, vecs[k].e_match,
                         vecs[k].e_err, vecs[k].e_first, vecs[k].e_pass);
        end

        // Randomized runs against a counting model of the first n valid samples
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 25);
            for (int i = 0; i < 64; i++) fault_map[i] = ($urandom_range(0, 3) == 0);
            e_err = 0;
            e_first = 65535;
            for (int i = 0; i < n; i++) begin
                if (fault_map[i]) begin
                    if (e_err == 0) e_first = i;
                    e_err++;
                end
            end
            do_run(n, 2, -1, done_c, last_c, busy0);
            check_result($sformatf("rand%0d", r), done_c, last_c, busy0, n - e_err, e_err,
                         e_first, (e_err == 0) ? 1 : 0);
        end

        // Reset mid-run after 5 compares, then a fresh 4-check run
        clear_faults();
        @(posedge clock); #1;
        start = 1'b1;
        num_checks = CNT_W'(20);
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din_valid = (c < 5);
            din = DATA_W'($urandom);
            @(posedge clock); #1;
        end
        din_valid = 1'b0;
        chk("midrun match_count", match_count, 5);
        chk("midrun busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort match_count", match_count, 0);
        chk("abort err_count", err_count, 0);
        chk("abort first_err", first_err, 16'hFFFF);
        @(posedge clock); #1;
        rst = 1'b0;
        do_run(4, 0, -1, done_c, last_c, busy0);
        check_result("after_abort", done_c, last_c, busy0, 4, 0, 65535, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
